// File: rtl/vgabuffer_arbiter_if.sv
// Bus bundle between the display pipeline, the drawing engine, the
// frame-buffer arbiter and the frame buffer.
// slave  : the arbiter's view of the bundle.
// master : the environment's view (both requesters plus the buffer).
interface vgabuffer_arbiter_if;
  // scan-out requester
  logic        scan_req;
  logic [11:0] scan_x;
  logic [11:0] scan_y;
  logic        scan_ack;
  logic        scan_rvalid;
  logic [11:0] scan_rdata;
  // drawing engine
  logic        draw_req;
  logic        draw_wen;
  logic [11:0] draw_x;
  logic [11:0] draw_y;
  logic [11:0] draw_wdata;
  logic        draw_ack;
  logic        draw_rvalid;
  logic [11:0] draw_rdata;
  // frame buffer
  logic [11:0] buf_x;
  logic [11:0] buf_y;
  logic [11:0] buf_wdata;
  logic        buf_select;
  logic        buf_wen;
  logic [11:0] buf_rdata;
  // status
  logic        busy;

  modport slave (
    input  scan_req, scan_x, scan_y,
    input  draw_req, draw_wen, draw_x, draw_y, draw_wdata,
    input  buf_rdata,
    output scan_ack, scan_rvalid, scan_rdata,
    output draw_ack, draw_rvalid, draw_rdata,
    output buf_x, buf_y, buf_wdata, buf_select, buf_wen,
    output busy
  );

  modport master (
    output scan_req, scan_x, scan_y,
    output draw_req, draw_wen, draw_x, draw_y, draw_wdata,
    output buf_rdata,
    input  scan_ack, scan_rvalid, scan_rdata,
    input  draw_ack, draw_rvalid, draw_rdata,
    input  buf_x, buf_y, buf_wdata, buf_select, buf_wen,
    input  busy
  );
endinterface

// File: rtl/vgabuffer_arbiter.sv
// Frame-buffer arbiter: serialises scan-out reads and draw reads/writes
// into fixed slots (IDLE -> ACCESS x SLOT_CYCLES -> CAPTURE) on the
// single-ported 320x240x12 buffer. Scan wins ties, except that draw is
// forced after STARVE_LIMIT consecutive scan grants made while draw waits.
// Out-of-range accesses keep slot timing but never select the buffer;
// their reads return 12'h000.
// Optional: define VGABUFFER_ARBITER_STATS_EN to add the saturating
// oob_count and starve_events outputs.
module vgabuffer_arbiter #(
  parameter int BUFFER_X     = 320,
  parameter int BUFFER_Y     = 240,
  parameter int SLOT_CYCLES  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               aclk4,
  input  logic               aresetn,
  vgabuffer_arbiter_if.slave bus
`ifdef VGABUFFER_ARBITER_STATS_EN
  ,
  output logic [15:0]        oob_count,
  output logic [15:0]        starve_events
`endif
);

  localparam int          CW         = $clog2(SLOT_CYCLES);
  localparam int          SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] SLOT_LOAD  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [11:0] X_LIM      = 12'(BUFFER_X);
  localparam logic [11:0] Y_LIM      = 12'(BUFFER_Y);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;
  typedef enum logic {OWN_SCAN, OWN_DRAW} owner_e;

  state_e        state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [11:0]   buf_x_q, buf_y_q, buf_wdata_q;
  logic          wen_q;
  logic          in_range_q;
  owner_e        owner_q;
  logic [11:0]   scan_rdata_q, draw_rdata_q;

  logic          idle_live;
  logic          starved;
  logic          draw_go, scan_go, grant;
  logic [11:0]   sel_x, sel_y;
  logic          sel_in_range;
  logic          rd_capture;
  logic [11:0]   cap_data;

  // Arbitration for the current IDLE cycle. The ack is a Mealy output of
  // IDLE, so it is also qualified by aresetn to keep it low during reset.
  always_comb begin
    idle_live    = (state_q == IDLE) && aresetn;
    starved      = (starve_q == STARVE_MAX);
    draw_go      = idle_live && bus.draw_req && (!bus.scan_req || starved);
    scan_go      = idle_live && bus.scan_req && !draw_go;
    grant        = draw_go || scan_go;
    sel_x        = draw_go ? bus.draw_x : bus.scan_x;
    sel_y        = draw_go ? bus.draw_y : bus.scan_y;
    sel_in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
  end

  // State register.
  always_ff @(posedge aclk4 or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state logic: one IDLE cycle, SLOT_CYCLES ACCESS cycles, one CAPTURE.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a
    // variable unassigned and infers a latch.
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          slot_d  = SLOT_LOAD;
        end
      end
      ACCESS: begin
        if (slot_q == '0) state_d = CAPTURE;
        else              slot_d  = slot_q - 1'b1;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state plus the latched slot owner and operands.
  always_comb begin
    rd_capture      = (state_q == CAPTURE) && !wen_q;
    cap_data        = in_range_q ? bus.buf_rdata : 12'h000;
    bus.scan_ack    = scan_go;
    bus.draw_ack    = draw_go;
    bus.buf_select  = (state_q == ACCESS) && in_range_q;
    bus.buf_wen     = (state_q == ACCESS) && in_range_q && wen_q;
    bus.busy        = (state_q != IDLE);
    bus.scan_rvalid = rd_capture && (owner_q == OWN_SCAN);
    bus.draw_rvalid = rd_capture && (owner_q == OWN_DRAW);
    bus.scan_rdata  = bus.scan_rvalid ? cap_data : scan_rdata_q;
    bus.draw_rdata  = bus.draw_rvalid ? cap_data : draw_rdata_q;
  end

  assign bus.buf_x     = buf_x_q;
  assign bus.buf_y     = buf_y_q;
  assign bus.buf_wdata = buf_wdata_q;

  // Starvation counter: counts scan grants while draw waits, clears when
  // draw is granted or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (!bus.draw_req || draw_go)  starve_d = '0;
    else if (scan_go && !starved)  starve_d = starve_q + 1'b1;
  end

  // Operand latch at grant, starvation counter and held read-data registers.
  always_ff @(posedge aclk4 or negedge aresetn) begin
    if (!aresetn) begin
      buf_x_q      <= '0;
      buf_y_q      <= '0;
      buf_wdata_q  <= '0;
      wen_q        <= 1'b0;
      in_range_q   <= 1'b0;
      owner_q      <= OWN_SCAN;
      starve_q     <= '0;
      scan_rdata_q <= '0;
      draw_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (grant) begin
        buf_x_q     <= sel_x;
        buf_y_q     <= sel_y;
        buf_wdata_q <= draw_go ? bus.draw_wdata : 12'h000;
        wen_q       <= draw_go && bus.draw_wen;
        in_range_q  <= sel_in_range;
        owner_q     <= draw_go ? OWN_DRAW : OWN_SCAN;
      end
      if (bus.scan_rvalid) scan_rdata_q <= cap_data;
      if (bus.draw_rvalid) draw_rdata_q <= cap_data;
    end
  end

`ifdef VGABUFFER_ARBITER_STATS_EN
  logic [15:0] oob_count_q, starve_events_q;

  // Saturating event counters for out-of-range and forced-draw grants.
  always_ff @(posedge aclk4 or negedge aresetn) begin
    if (!aresetn) begin
      oob_count_q     <= '0;
      starve_events_q <= '0;
    end else begin
      if (grant && !sel_in_range && (oob_count_q != 16'hFFFF))
        oob_count_q <= oob_count_q + 16'd1;
      if (draw_go && bus.scan_req && starved && (starve_events_q != 16'hFFFF))
        starve_events_q <= starve_events_q + 16'd1;
    end
  end

  assign oob_count     = oob_count_q;
  assign starve_events = starve_events_q;
`endif

endmodule

// File: tb/tb_vgabuffer_arbiter.sv
// Directed bench for vgabuffer_arbiter with a slow frame-buffer model:
// registered reads while selected, and a write commits only once select
// and wen have been held for a full slot.
module tb_vgabuffer_arbiter;

  localparam int BX   = 320;
  localparam int BY   = 240;
  localparam int SLOT = 4;

  logic clk;
  logic rst_n;

  vgabuffer_arbiter_if bus_if ();

`ifdef VGABUFFER_ARBITER_STATS_EN
  logic [15:0] oob_count;
  logic [15:0] starve_events;
`endif

  vgabuffer_arbiter #(
    .BUFFER_X(BX), .BUFFER_Y(BY), .SLOT_CYCLES(SLOT), .STARVE_LIMIT(8)
  ) dut (
    .aclk4   (clk),
    .aresetn (rst_n),
    .bus     (bus_if)
`ifdef VGABUFFER_ARBITER_STATS_EN
    ,
    .oob_count     (oob_count),
    .starve_events (starve_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame-buffer model
  logic [11:0] mem [0:BX*BY-1];
  logic [11:0] rdata_m;
  int          sel_run;

  function automatic int idx(input logic [11:0] x, input logic [11:0] y);
    return int'(y) * BX + int'(x);
  endfunction

  always @(posedge clk) begin
    if (bus_if.buf_select) begin
      rdata_m <= mem[idx(bus_if.buf_x, bus_if.buf_y)];
      if (bus_if.buf_wen && sel_run == SLOT - 1)
        mem[idx(bus_if.buf_x, bus_if.buf_y)] = bus_if.buf_wdata;
      sel_run <= sel_run + 1;
    end else begin
      sel_run <= 0;
    end
  end
  assign bus_if.buf_rdata = rdata_m;

  int total = 0;
  int bad   = 0;
  int grants[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " scan_ack"},    32'(bus_if.scan_ack),    0);
    check({tag, " draw_ack"},    32'(bus_if.draw_ack),    0);
    check({tag, " scan_rvalid"}, 32'(bus_if.scan_rvalid), 0);
    check({tag, " draw_rvalid"}, 32'(bus_if.draw_rvalid), 0);
    check({tag, " scan_rdata"},  32'(bus_if.scan_rdata),  0);
    check({tag, " draw_rdata"},  32'(bus_if.draw_rdata),  0);
    check({tag, " buf_select"},  32'(bus_if.buf_select),  0);
    check({tag, " buf_wen"},     32'(bus_if.buf_wen),     0);
    check({tag, " buf_x"},       32'(bus_if.buf_x),       0);
    check({tag, " buf_y"},       32'(bus_if.buf_y),       0);
    check({tag, " buf_wdata"},   32'(bus_if.buf_wdata),   0);
    check({tag, " busy"},        32'(bus_if.busy),        0);
  endtask

  // One isolated transaction: request, ack at cycle 0, ACCESS cycles 1..SLOT,
  // CAPTURE at cycle SLOT+1, then one cycle to confirm rdata is held.
  task automatic do_slot(input string tag, input bit is_draw, input bit wen,
                         input logic [11:0] x, input logic [11:0] y, input logic [11:0] wd,
                         input int exp_sel, input bit exp_rv, input logic [11:0] exp_rd);
    int  sel_n;
    int  wen_n;
    int  guard;
    bit  acked;
    @(posedge clk); #1;
    if (is_draw) begin
      bus_if.draw_req = 1'b1; bus_if.draw_wen = wen;
      bus_if.draw_x = x; bus_if.draw_y = y; bus_if.draw_wdata = wd;
    end else begin
      bus_if.scan_req = 1'b1; bus_if.scan_x = x; bus_if.scan_y = y;
    end
    acked = 1'b0;
    guard = 0;
    while (!acked && guard < 20) begin
      @(negedge clk);
      acked = is_draw ? bus_if.draw_ack : bus_if.scan_ack;
      guard++;
    end
    check({tag, " ack"}, 32'(acked), 1);
    check({tag, " busy@ack"}, 32'(bus_if.busy), 0);
    @(posedge clk); #1;
    bus_if.draw_req = 1'b0;
    bus_if.scan_req = 1'b0;
    sel_n = 0;
    wen_n = 0;
    for (int c = 1; c <= SLOT; c++) begin
      @(negedge clk);
      if (bus_if.buf_select) sel_n++;
      if (bus_if.buf_wen)    wen_n++;
      if (c == 1) begin
        check({tag, " busy"},  32'(bus_if.busy),  1);
        check({tag, " buf_x"}, 32'(bus_if.buf_x), 32'(x));
        check({tag, " buf_y"}, 32'(bus_if.buf_y), 32'(y));
      end
    end
    check({tag, " sel cycles"}, 32'(sel_n), 32'(exp_sel));
    check({tag, " wen cycles"}, 32'(wen_n), wen ? 32'(exp_sel) : 0);
    @(negedge clk);
    check({tag, " sel@capture"}, 32'(bus_if.buf_select), 0);
    if (is_draw) begin
      check({tag, " rvalid"}, 32'(bus_if.draw_rvalid), 32'(exp_rv));
      check({tag, " other rvalid"}, 32'(bus_if.scan_rvalid), 0);
      if (exp_rv) check({tag, " rdata"}, 32'(bus_if.draw_rdata), 32'(exp_rd));
    end else begin
      check({tag, " rvalid"}, 32'(bus_if.scan_rvalid), 32'(exp_rv));
      check({tag, " other rvalid"}, 32'(bus_if.draw_rvalid), 0);
      if (exp_rv) check({tag, " rdata"}, 32'(bus_if.scan_rdata), 32'(exp_rd));
    end
    @(negedge clk);
    check({tag, " rvalid drop"}, 32'(bus_if.scan_rvalid | bus_if.draw_rvalid), 0);
    check({tag, " idle"}, 32'(bus_if.busy), 0);
    if (exp_rv)
      check({tag, " rdata hold"}, is_draw ? 32'(bus_if.draw_rdata) : 32'(bus_if.scan_rdata), 32'(exp_rd));
  endtask

  initial begin
    int cyc;
    int last;
    int ack_n;
    for (int i = 0; i < BX * BY; i++) mem[i] = 12'h000;
    mem[idx(12'd5, 12'd2)]   = 12'h777;
    mem[idx(12'd20, 12'd20)] = 12'h055;

    rst_n = 1'b0;
    bus_if.scan_req = 1'b1; bus_if.scan_x = 12'd5; bus_if.scan_y = 12'd2;
    bus_if.draw_req = 1'b0; bus_if.draw_wen = 1'b0;
    bus_if.draw_x = '0; bus_if.draw_y = '0; bus_if.draw_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    bus_if.scan_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // basic scan read
    do_slot("scan rd", 1'b0, 1'b0, 12'd5, 12'd2, 12'h000, SLOT, 1'b1, 12'h777);

    // draw write then read back
    do_slot("draw wr", 1'b1, 1'b1, 12'd10, 12'd10, 12'hABC, SLOT, 1'b0, 12'h000);
    check("mem after wr", 32'(mem[idx(12'd10, 12'd10)]), 32'h0ABC);
    do_slot("draw rd", 1'b1, 1'b0, 12'd10, 12'd10, 12'h000, SLOT, 1'b1, 12'hABC);

    // continuous contention: 8 scan grants, 1 forced draw grant, repeat
    @(posedge clk); #1;
    bus_if.scan_req = 1'b1; bus_if.scan_x = 12'd5;  bus_if.scan_y = 12'd2;
    bus_if.draw_req = 1'b1; bus_if.draw_wen = 1'b0;
    bus_if.draw_x = 12'd10; bus_if.draw_y = 12'd10;
    last = 0;
    cyc = 0;
    while (cyc < 300 && grants.size() < 20) begin
      @(negedge clk);
      ack_n = int'(bus_if.scan_ack) + int'(bus_if.draw_ack);
      if (ack_n > 1) check("dual ack", 32'(ack_n), 1);
      if (ack_n == 1) begin
        if (grants.size() > 0) check("grant spacing", 32'(cyc - last), SLOT + 2);
        grants.push_back(int'(bus_if.draw_ack));
        last = cyc;
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus_if.scan_req = 1'b0;
    bus_if.draw_req = 1'b0;
    check("grant count", 32'(grants.size()), 20);
    foreach (grants[i])
      check($sformatf("grant %0d is draw", i), 32'(grants[i]), (i % 9 == 8) ? 1 : 0);
    repeat (SLOT + 4) @(posedge clk);

    // out-of-range accesses: no select, rdata forced to zero
    do_slot("oob draw rd", 1'b1, 1'b0, 12'd320, 12'd0, 12'h000, 0, 1'b1, 12'h000);
    do_slot("oob scan rd", 1'b0, 1'b0, 12'd0, 12'd240, 12'h000, 0, 1'b1, 12'h000);
    do_slot("oob draw wr", 1'b1, 1'b1, 12'd400, 12'd5, 12'hFFF, 0, 1'b0, 12'h000);
`ifdef VGABUFFER_ARBITER_STATS_EN
    check("oob_count", 32'(oob_count), 3);
    check("starve_events", 32'(starve_events), 2);
`endif

    // reset in the middle of a draw write
    @(posedge clk); #1;
    bus_if.draw_req = 1'b1; bus_if.draw_wen = 1'b1;
    bus_if.draw_x = 12'd20; bus_if.draw_y = 12'd20; bus_if.draw_wdata = 12'h123;
    @(negedge clk);
    check("rst wr ack", 32'(bus_if.draw_ack), 1);
    @(posedge clk); #1;
    bus_if.draw_req = 1'b0;
    @(negedge clk);
    check("rst wr sel", 32'(bus_if.buf_select & bus_if.buf_wen), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_all_zero("midslot reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ack_n += int'(bus_if.draw_ack) + int'(bus_if.draw_rvalid) + int'(bus_if.buf_select);
    end
    check("post reset quiet", 32'(ack_n), 0);
    check("pixel unchanged", 32'(mem[idx(12'd20, 12'd20)]), 32'h055);

    do_slot("post rst scan", 1'b0, 1'b0, 12'd5, 12'd2, 12'h000, SLOT, 1'b1, 12'h777);
    do_slot("post rst wr", 1'b1, 1'b1, 12'd20, 12'd20, 12'h123, SLOT, 1'b0, 12'h000);
    do_slot("post rst rd", 1'b1, 1'b0, 12'd20, 12'd20, 12'h000, SLOT, 1'b1, 12'h123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vgabuffer_arbiter.md
Name: vgabuffer_arbiter

Overview:
Shares the single-ported 320x240x12 frame buffer between two requesters. The scan-out read port is latency-critical; the draw port issues reads or writes. Sits between the display pipeline, the drawing engine and the frame buffer. It serialises accesses into fixed-length slots and owns the buffer's select/wen/address/wdata inputs. It returns read data to the requester that issued the read.

Parameters:
BUFFER_X, 320, frame width in pixels; valid x is 0..BUFFER_X-1
BUFFER_Y, 240, frame height in pixels; valid y is 0..BUFFER_Y-1
SLOT_CYCLES, 4, cycles buf_select is held per access (min 3)
STARVE_LIMIT, 8, consecutive scan grants while draw_req is pending before draw is forced

Ports:
aclk4  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
scan_req  in  1  scan-out read request
scan_x  in  12  scan pixel x
scan_y  in  12  scan pixel y
scan_ack  out  1  one-cycle pulse: scan request latched
scan_rvalid  out  1  one-cycle pulse: scan_rdata valid
scan_rdata  out  12  scan read data
draw_req  in  1  draw request
draw_wen  in  1  1=write, 0=read
draw_x  in  12  draw pixel x
draw_y  in  12  draw pixel y
draw_wdata  in  12  draw write data
draw_ack  out  1  one-cycle pulse: draw request latched
draw_rvalid  out  1  one-cycle pulse: draw_rdata valid (reads only)
draw_rdata  out  12  draw read data
buf_x  out  12  buffer address x
buf_y  out  12  buffer address y
buf_wdata  out  12  buffer write data
buf_select  out  1  buffer select
buf_wen  out  1  buffer write enable
buf_rdata  in  12  buffer registered read data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: every output 0, FSM in IDLE, starve counter 0. Reset asserted mid-slot abandons the transaction; no ack or rvalid is issued for it afterwards.
- FSM states: IDLE -> ACCESS -> CAPTURE -> IDLE.
- IDLE to ACCESS, on any request:
  - Pick the winner.
  - Latch its x, y, wen and wdata into buf_* registers. Scan always uses wen=0.
  - Pulse the winner's ack in the same cycle.
  - Load the slot counter with SLOT_CYCLES-1.
- ACCESS:
  - buf_select=1 and buf_* held stable for exactly SLOT_CYCLES cycles.
  - The counter decrements each cycle; on 0, go to CAPTURE.
- CAPTURE:
  - buf_select=0 and buf_wen=0.
  - For a read, sample buf_rdata into the owner's rdata and pulse its rvalid.
  - For a write, no rvalid.
  - Always return to IDLE.
- Slot length and throughput:
  - IDLE is occupied for at least one cycle between slots.
  - Slot is SLOT_CYCLES+2 cycles from ack to the next possible ack.
  - Read latency from ack to rvalid is SLOT_CYCLES+1.
- Arbitration:
  - Scan wins ties.
  - Starve counter increments on each scan grant made while draw_req=1, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and draw_req=1, draw wins.
  - Counter clears on any draw grant, or in any cycle where draw_req=0.
- Handshake:
  - A requester holds req and operands stable until its ack.
  - req still high the cycle after ack is treated as a new request.
- Out of range (x>=BUFFER_X or y>=BUFFER_Y):
  - Slot timing and ack are unchanged, but buf_select stays 0 for the whole slot.
  - Reads return 12'h000 with rvalid.
  - Writes are dropped.
- rdata registers hold their value until the next rvalid to the same port.

Optional Feature:
VGABUFFER_ARBITER_STATS_EN:
- Defined: adds output oob_count[15:0] and output starve_events[15:0].
  - oob_count increments on every out-of-range grant.
  - starve_events increments on every forced draw grant.
  - Both are saturating counters, reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Scan read (5,2) alone with buffer location holding 12'h777: scan_ack at cycle 0, buf_select high cycles 1-4 with buf_x=5/buf_y=2, scan_rvalid at cycle 5 with scan_rdata=12'h777.
- Draw write (10,10)=12'hABC, then draw read (10,10): buf_wen=1 for the whole first slot, draw_rvalid only on the second slot, draw_rdata=12'hABC.
- scan_req and draw_req both held high continuously: 8 scan grants, then 1 draw grant, then scan resumes; the pattern repeats.
- Draw read at (320,0) and scan read at (0,240): buf_select never asserts; both rvalid pulse with data 12'h000. With VGABUFFER_ARBITER_STATS_EN, oob_count=2.
- aresetn low at cycle 2 of a draw write: all outputs 0 immediately, no draw_ack repeat and no rvalid afterwards, the target pixel is unchanged, and after release the next request is served normally.
